// File: rtl/bitfusion_pkg.sv
// Shared widths and FSM encoding for the fusion-unit accumulator drain.
// Optional build macro ACC_DRAIN_RELU_EN selects the fused ReLU output.
package bitfusion_pkg;

  localparam int ACC_W     = 28;
  localparam int OUT_W     = 8;
  localparam int SHIFT     = 6;
  localparam int NUM_TERMS = 16;
  localparam int CNT_W     = 5;
  localparam int NUM_W     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WAIT_OUT = 2'd2,
    CAPTURE  = 2'd3
  } state_e;

endpackage

// File: rtl/acc_drain_if.sv
// Valid/ready result port of the accumulator drain.
// master drives data/valid, slave returns ready.
interface acc_drain_if
  import bitfusion_pkg::*;
#(
  parameter int W = OUT_W
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/acc_drain_requant.sv
// Round, arithmetic shift and saturate of the ACC total to OUT_W bits.
// ACC_DRAIN_RELU_EN defined: negative results clamp to zero.
module acc_requant
  import bitfusion_pkg::*;
#(
  parameter int AW = ACC_W,
  parameter int OW = OUT_W,
  parameter int SH = SHIFT
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [OW-1:0] q_o
);

  localparam int RS = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [AW:0] ONE  = 1;
  localparam logic signed [AW:0] RND  = (SH > 0) ? (ONE <<< RS) : '0;
  localparam logic signed [AW:0] MAXV = (ONE <<< (OW - 1)) - ONE;
  localparam logic signed [AW:0] MINV = -(ONE <<< (OW - 1));

  logic signed [AW:0] ext;
  logic signed [AW:0] t;
  logic signed [AW:0] y;
  logic signed [AW:0] s;

  // one guard bit keeps the rounding add from wrapping
  always_comb begin
    ext = {acc_i[AW-1], acc_i};
    t   = ext + RND;
    y   = t >>> SH;
    s   = y;
    if (y > MAXV) begin
      s = MAXV;
    end else if (y < MINV) begin
      s = MINV;
    end
`ifdef ACC_DRAIN_RELU_EN
    if (s < 0) begin
      s = '0;
    end
`else
`endif
    q_o = s[OW-1:0];
  end

endmodule

// File: rtl/acc_drain.sv
// Counts PE_sum beats into ACC, captures and clears it, drains requantized result.
// ACC_DRAIN_RELU_EN (see acc_requant) enables fused ReLU on the output.
module acc_drain
  import bitfusion_pkg::*;
#(
  parameter int ACC_W_P     = ACC_W,
  parameter int OUT_W_P     = OUT_W,
  parameter int SHIFT_P     = SHIFT,
  parameter int NUM_TERMS_P = NUM_TERMS,
  parameter int CNT_W_P     = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_W-1:0]   num_out,
  input  logic               pe_sum_valid,
  input  logic [ACC_W_P-1:0] acc_total,
  output logic               acc_clear,
  output logic               pe_stall,
  acc_drain_if.master        out_if,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  logic [CNT_W_P-1:0]   cnt_q, cnt_d;
  logic [CNT_W_P-1:0]   cnt_inc;
  logic [NUM_W-1:0]     rem_q, rem_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W_P-1:0]   out_data_q, out_data_d;
  logic                 done_q, done_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic signed [OUT_W_P-1:0] req_data;

  acc_requant #(
    .AW (ACC_W_P),
    .OW (OUT_W_P),
    .SH (SHIFT_P)
  ) u_requant (
    .acc_i (acc_total),
    .q_o   (req_data)
  );

  assign accept  = out_valid_q & out_if.ready;
  assign cnt_inc = cnt_q + CNT_W_P'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    done_d      = accept & last_q;
    acc_clear   = 1'b0;
    pe_stall    = 1'b1;
    if (accept) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        acc_clear = 1'b1;
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          rem_d   = (num_out == '0) ? NUM_W'(1) : num_out;
        end
      end
      ACCUM: begin
        pe_stall = 1'b0;
        if (pe_sum_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W_P'(NUM_TERMS_P)) begin
            state_d = (!out_valid_q || accept) ? CAPTURE : WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (accept) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // ACC clears on this same edge, so the next output overlaps the drain
        acc_clear   = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = req_data;
        last_d      = (rem_q == NUM_W'(1));
        rem_d       = rem_q - NUM_W'(1);
        cnt_d       = '0;
        state_d     = (rem_q > NUM_W'(1)) ? ACCUM : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      last_q      <= last_d;
    end
  end

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign busy         = (state_q != IDLE) | out_valid_q;
  assign done         = done_q;

endmodule
